attn_seq_ctrl: RTL and testbench

- Parametrised top-level sequencer for the attention datapath. Successor to the single-head fixed-length controller.
- Drives the weight/input DMA, QKV CIM engine, QK engine, softmax engine and score-store DMA through level enable / done-pulse handshakes.
- Supports a runtime sequence length, NUM_HEADS heads with per-head weight address offsets, overlap of softmax(t-1) with QK(t), a final drain, and a clean start/busy/done/abort interface.

---
 rtl/attn_pkg.sv | 28 ++
 rtl/attn_seq_ctrl_hs_join.sv | 22 ++
 rtl/attn_seq_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_attn_seq_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/attn_pkg.sv
// Shared types and constants for the attention sequencer slice.
package attn_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LW_Q,
    S_LW_K,
    S_LW_V,
    S_LX,
    S_PK,
    S_PREP,
    S_TLQ,
    S_TQK,
    S_TST,
    S_DRAIN,
    S_NH,
    S_FIN
  } state_e;

  localparam logic [1:0] SEL_Q = 2'd0;
  localparam logic [1:0] SEL_K = 2'd1;
  localparam logic [1:0] SEL_V = 2'd2;
  localparam logic [1:0] SEL_X = 2'd3;

  localparam logic [31:0] DEF_ADDR_RST    = 32'h0000_0000;
  localparam logic [31:0] DEF_HEAD_STRIDE = 32'h0001_0000;

endpackage

// File: rtl/attn_seq_ctrl_hs_join.sv
// Sticky done-flag collector: all_done_o is high once every required branch has reported.
module hs_join #(
  parameter int unsigned N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic [N-1:0] hit_i,
  input  logic [N-1:0] need_i,
  output logic         all_done_o
);

  logic [N-1:0] flags_q;

  always_ff @(posedge clk) begin
    if (rst || clr_i) flags_q <= '0;
    else              flags_q <= flags_q | hit_i;
  end

  assign all_done_o = &(flags_q | ~need_i);

endmodule

// File: rtl/attn_seq_ctrl.sv
// Multi-head attention sequencer: drives DMA and compute engines via enable/done handshakes.
module attn_seq_ctrl
  import attn_pkg::*;
#(
  parameter int unsigned       ADDR_W      = 32,
  parameter int unsigned       SEQ_W       = 16,
  parameter int unsigned       NUM_HEADS   = 4,
  parameter logic [ADDR_W-1:0] HEAD_STRIDE = ADDR_W'(DEF_HEAD_STRIDE)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [SEQ_W-1:0]  seq_len_cfg,
  input  logic [ADDR_W-1:0] q_base,
  input  logic [ADDR_W-1:0] k_base,
  input  logic [ADDR_W-1:0] v_base,
  input  logic [ADDR_W-1:0] x_base,
  input  logic              done_weight_dma,
  input  logic              done_cimeb,
  input  logic              done_loadk,
  input  logic              done_qk,
  input  logic              done_loadq,
  input  logic              done_softmax,
  input  logic              done_loadscore,
  output logic              en_weight_dma,
  output logic              en_cimeb,
  output logic              en_loadk,
  output logic              en_qk_kmode,
  output logic              en_qk_qmode,
  output logic              en_loadq,
  output logic              en_softmax,
  output logic              en_loadscore,
  output logic [ADDR_W-1:0] weight_addr,
  output logic [1:0]        weight_sel,
  output logic [3:0]        head_idx,
  output logic [SEQ_W-1:0]  tok_idx,
  output logic              busy,
  output logic              done
);

  state_e            state_q;
  logic              en_wdma_q, en_cimeb_q, en_loadk_q, en_qkk_q;
  logic              en_qkq_q, en_loadq_q, en_sm_q, en_ls_q;
  logic [ADDR_W-1:0] addr_q, qb_q, kb_q, vb_q, xb_q;
  logic [1:0]        sel_q;
  logic [3:0]        head_q;
  logic [SEQ_W-1:0]  tok_q, seq_len_q;
  logic              busy_q, done_q;

  logic hit_wdma, hit_cimeb, hit_loadk, hit_qk, hit_loadq, hit_sm, hit_ls;
  logic prep_all, tqk_all, drain_sm_done, last_head;

  assign hit_wdma  = done_weight_dma & en_wdma_q;
  assign hit_cimeb = done_cimeb      & en_cimeb_q;
  assign hit_loadk = done_loadk      & en_loadk_q;
  assign hit_qk    = done_qk         & en_qkq_q;
  assign hit_loadq = done_loadq      & en_loadq_q;
  assign hit_sm    = done_softmax    & en_sm_q;
  assign hit_ls    = done_loadscore  & en_ls_q;
  assign last_head = (head_q == 4'(NUM_HEADS - 1));

  function automatic logic [ADDR_W-1:0] head_off(input logic [3:0] h);
    return ADDR_W'(h) * HEAD_STRIDE;
  endfunction

  // Joins hold their flags only while their own state is active.
  hs_join #(.N(2)) u_join_prep (
    .clk(clk), .rst(rst), .clr_i(state_q != S_PREP),
    .hit_i({hit_loadk, hit_cimeb}), .need_i(2'b11), .all_done_o(prep_all)
  );
  hs_join #(.N(2)) u_join_tqk (
    .clk(clk), .rst(rst), .clr_i(state_q != S_TQK),
    .hit_i({hit_sm, hit_qk}), .need_i({tok_q != '0, 1'b1}), .all_done_o(tqk_all)
  );
  hs_join #(.N(1)) u_join_drain (
    .clk(clk), .rst(rst), .clr_i(state_q != S_DRAIN),
    .hit_i(hit_sm), .need_i(1'b1), .all_done_o(drain_sm_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      en_wdma_q <= 1'b0; en_cimeb_q <= 1'b0; en_loadk_q <= 1'b0; en_qkk_q <= 1'b0;
      en_qkq_q  <= 1'b0; en_loadq_q <= 1'b0; en_sm_q    <= 1'b0; en_ls_q  <= 1'b0;
      addr_q    <= ADDR_W'(DEF_ADDR_RST);
      qb_q <= '0; kb_q <= '0; vb_q <= '0; xb_q <= '0;
      sel_q     <= SEL_Q;
      head_q    <= '0;
      tok_q     <= '0;
      seq_len_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else if (abort && state_q != S_IDLE) begin
      state_q   <= S_IDLE;
      en_wdma_q <= 1'b0; en_cimeb_q <= 1'b0; en_loadk_q <= 1'b0; en_qkk_q <= 1'b0;
      en_qkq_q  <= 1'b0; en_loadq_q <= 1'b0; en_sm_q    <= 1'b0; en_ls_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      // Completed branches drop first; a state entry below may re-raise the same enable.
      if (hit_wdma)  en_wdma_q  <= 1'b0;
      if (hit_cimeb) en_cimeb_q <= 1'b0;
      if (hit_loadk) begin en_loadk_q <= 1'b0; en_qkk_q <= 1'b0; end
      if (hit_qk)    en_qkq_q   <= 1'b0;
      if (hit_loadq) en_loadq_q <= 1'b0;
      if (hit_sm)    en_sm_q    <= 1'b0;
      if (hit_ls)    en_ls_q    <= 1'b0;

      unique case (state_q)
        S_IDLE: if (start) begin
          seq_len_q <= (seq_len_cfg == '0) ? SEQ_W'(1) : seq_len_cfg;
          qb_q <= q_base; kb_q <= k_base; vb_q <= v_base; xb_q <= x_base;
          head_q <= '0; tok_q <= '0; busy_q <= 1'b1;
          en_wdma_q <= 1'b1; sel_q <= SEL_Q; addr_q <= q_base;
          state_q <= S_LW_Q;
        end
        S_LW_Q: if (hit_wdma) begin
          en_wdma_q <= 1'b1; sel_q <= SEL_K; addr_q <= kb_q + head_off(head_q);
          state_q <= S_LW_K;
        end
        S_LW_K: if (hit_wdma) begin
          en_wdma_q <= 1'b1; sel_q <= SEL_V; addr_q <= vb_q + head_off(head_q);
          state_q <= S_LW_V;
        end
        S_LW_V: if (hit_wdma) begin
          en_wdma_q <= 1'b1; sel_q <= SEL_X; addr_q <= xb_q;
          state_q <= S_LX;
        end
        S_LX: if (hit_wdma) begin
          en_cimeb_q <= 1'b1; sel_q <= SEL_K;
          state_q <= S_PK;
        end
        S_PK: if (hit_cimeb) begin
          en_cimeb_q <= 1'b1; en_loadk_q <= 1'b1; en_qkk_q <= 1'b1; sel_q <= SEL_Q;
          state_q <= S_PREP;
        end
        S_PREP: if (prep_all) begin
          en_loadq_q <= 1'b1;
          state_q <= S_TLQ;
        end
        S_TLQ: if (hit_loadq) begin
          en_qkq_q <= 1'b1;
          en_sm_q  <= (tok_q != '0);
          state_q  <= S_TQK;
        end
        S_TQK: if (tqk_all) begin
          tok_q <= tok_q + SEQ_W'(1);
          if (tok_q != '0) begin
            en_ls_q <= 1'b1; state_q <= S_TST;
          end else if (seq_len_q == SEQ_W'(1)) begin
            en_sm_q <= 1'b1; state_q <= S_DRAIN;
          end else begin
            en_loadq_q <= 1'b1; state_q <= S_TLQ;
          end
        end
        S_TST: if (hit_ls) begin
          if (tok_q < seq_len_q) begin en_loadq_q <= 1'b1; state_q <= S_TLQ;   end
          else                   begin en_sm_q    <= 1'b1; state_q <= S_DRAIN; end
        end
        // The last head finishes straight from here so done trails the final store by one cycle.
        S_DRAIN: begin
          if (hit_sm) en_ls_q <= 1'b1;
          if (drain_sm_done && hit_ls) begin
            if (last_head) begin
              done_q <= 1'b1; busy_q <= 1'b0; state_q <= S_FIN;
            end else begin
              state_q <= S_NH;
            end
          end
        end
        S_NH: begin
          head_q <= head_q + 4'd1; tok_q <= '0;
          en_wdma_q <= 1'b1; sel_q <= SEL_Q; addr_q <= qb_q + head_off(head_q + 4'd1);
          state_q <= S_LW_Q;
        end
        S_FIN:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign en_weight_dma = en_wdma_q;
  assign en_cimeb      = en_cimeb_q;
  assign en_loadk      = en_loadk_q;
  assign en_qk_kmode   = en_qkk_q;
  assign en_qk_qmode   = en_qkq_q;
  assign en_loadq      = en_loadq_q;
  assign en_softmax    = en_sm_q;
  assign en_loadscore  = en_ls_q;
  assign weight_addr   = addr_q;
  assign weight_sel    = sel_q;
  assign head_idx      = head_q;
  assign tok_idx       = tok_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_attn_seq_ctrl.sv
// Bench for attn_seq_ctrl: a phase-level script of the run plays the engines and predicts every output cycle.
module tb_attn_seq_ctrl;

  localparam int unsigned AW = 32;
  localparam int unsigned SW = 16;
  localparam int unsigned NH = 4;
  localparam logic [31:0] STRIDE = 32'h0001_0000;

  logic clk = 1'b0;
  logic rst = 1'b1, start = 1'b0, abort = 1'b0;
  logic [SW-1:0] seq_len_cfg = '0;
  logic [AW-1:0] q_base = '0, k_base = '0, v_base = '0, x_base = '0;
  logic [7:0] dn = '0;
  logic en_weight_dma, en_cimeb, en_loadk, en_qk_kmode, en_qk_qmode, en_loadq, en_softmax, en_loadscore;
  logic [AW-1:0] weight_addr;
  logic [1:0] weight_sel;
  logic [3:0] head_idx;
  logic [SW-1:0] tok_idx;
  logic busy, done;
  logic [7:0] dut_en;

  // Bit order for enable/done vectors: wdma, cimeb, loadk, qk_k, qk_q, loadq, softmax, loadscore.
  assign dut_en = {en_weight_dma, en_cimeb, en_loadk, en_qk_kmode, en_qk_qmode, en_loadq, en_softmax, en_loadscore};

  always #5 clk = ~clk;

  attn_seq_ctrl #(.ADDR_W(AW), .SEQ_W(SW), .NUM_HEADS(NH), .HEAD_STRIDE(STRIDE)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .seq_len_cfg(seq_len_cfg),
    .q_base(q_base), .k_base(k_base), .v_base(v_base), .x_base(x_base),
    .done_weight_dma(dn[7]), .done_cimeb(dn[6]), .done_loadk(dn[5]), .done_qk(dn[4] | dn[3]),
    .done_loadq(dn[2]), .done_softmax(dn[1]), .done_loadscore(dn[0]),
    .en_weight_dma(en_weight_dma), .en_cimeb(en_cimeb), .en_loadk(en_loadk),
    .en_qk_kmode(en_qk_kmode), .en_qk_qmode(en_qk_qmode), .en_loadq(en_loadq),
    .en_softmax(en_softmax), .en_loadscore(en_loadscore),
    .weight_addr(weight_addr), .weight_sel(weight_sel), .head_idx(head_idx),
    .tok_idx(tok_idx), .busy(busy), .done(done)
  );

  logic [7:0]    exp_en = '0;
  logic          exp_busy = 1'b0, exp_done = 1'b0;
  logic [3:0]    exp_head = '0;
  logic [SW-1:0] exp_tok = '0;
  logic [1:0]    exp_sel = '0;
  logic [AW-1:0] exp_addr = '0;
  bit chk_on = 0, fixed_d = 0, noise_on = 0, mid_start = 0;
  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s at %0t: actual=%h expected=%h", name, $time, act, expv);
    end
  endtask

  always @(negedge clk) if (chk_on) begin
    chk("enables", 32'(dut_en), 32'(exp_en));
    chk("busy", 32'(busy), 32'(exp_busy));
    chk("done", 32'(done), 32'(exp_done));
    if (exp_busy) begin
      chk("head_idx", 32'(head_idx), 32'(exp_head));
      chk("tok_idx", 32'(tok_idx), 32'(exp_tok));
    end
    if (exp_en[7]) chk("weight_addr", weight_addr, exp_addr);
    if (exp_en[7] || exp_en[6]) chk("weight_sel", 32'(weight_sel), 32'(exp_sel));
  end

  // Observers feeding the literal end-of-run expectations.
  logic prev_ls = 1'b0, prev_lq = 1'b0, prev_wd = 1'b0;
  logic [31:0] prev_addr = '0, h2_addr = '0;
  int ls_rise = 0, lq_rise = 0, done_cnt = 0;
  int head_vis [4] = '{0, 0, 0, 0};
  logic [31:0] addr_q [$];
  always @(negedge clk) begin
    if (en_loadscore && !prev_ls) ls_rise++;
    if (en_loadq && !prev_lq) lq_rise++;
    if (done) done_cnt++;
    if (en_weight_dma && !prev_wd) head_vis[head_idx[1:0]]++;
    if (en_weight_dma && (!prev_wd || weight_addr != prev_addr)) addr_q.push_back(weight_addr);
    if (en_weight_dma && head_idx == 4'd2 && weight_sel == 2'd0) h2_addr = weight_addr;
    prev_ls = en_loadscore; prev_lq = en_loadq; prev_wd = en_weight_dma; prev_addr = weight_addr;
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
    dn = '0; start = 1'b0; abort = 1'b0;
  endtask

  // Stray done pulses only on lines whose enable is low, plus start/config churn mid-run.
  task automatic noise();
    int unsigned i;
    logic line_en;
    if (!noise_on) return;
    if ($urandom_range(0, 3) == 0) begin
      i = $urandom_range(0, 7);
      line_en = (i == 3 || i == 4) ? (exp_en[3] | exp_en[4]) : exp_en[i];
      if (!line_en) dn[i] = 1'b1;
    end
    if (exp_busy && $urandom_range(0, 15) == 0) begin
      start = 1'b1; seq_len_cfg = 16'd7;
      q_base = $urandom; k_base = $urandom; v_base = $urandom; x_base = $urandom;
    end
  endtask

  // One state: each branch stays enabled for its delay, its done arrives in its last cycle.
  task automatic run_state(input logic [7:0] br, input bit is_join);
    int unsigned d [8];
    int unsigned maxd = 0;
    for (int unsigned i = 0; i < 8; i++) begin
      d[i] = br[i] ? (fixed_d ? 3 : $urandom_range(1, 4)) : 0;
    end
    if (br[4]) d[4] = d[5];
    for (int unsigned i = 0; i < 8; i++) if (d[i] > maxd) maxd = d[i];
    for (int unsigned c = 1; c <= maxd; c++) begin
      for (int unsigned i = 0; i < 8; i++) begin
        exp_en[i] = (c <= d[i]);
        if (c == d[i] && i != 4) dn[i] = 1'b1;
      end
      noise();
      next_cycle();
    end
    if (is_join) begin
      exp_en = '0;
      noise();
      next_cycle();
    end
  endtask

  task automatic do_run(input logic [SW-1:0] cfg, input logic [AW-1:0] qb, kb, vb, xb, input int abort_h);
    int unsigned L, t;
    seq_len_cfg = cfg; q_base = qb; k_base = kb; v_base = vb; x_base = xb;
    start = 1'b1; exp_en = '0; exp_busy = 1'b0; exp_done = 1'b0;
    next_cycle();
    L = (cfg == 0) ? 1 : int'(cfg);
    exp_busy = 1'b1;
    for (int unsigned h = 0; h < NH; h++) begin
      exp_head = h[3:0]; exp_tok = '0; t = 0;
      if (mid_start && h == 1) begin
        start = 1'b1; seq_len_cfg = 16'd7; q_base = ~qb; x_base = ~xb;
      end
      exp_sel = 2'd0; exp_addr = qb + AW'(h) * STRIDE; run_state(8'h80, 0);
      exp_sel = 2'd1; exp_addr = kb + AW'(h) * STRIDE; run_state(8'h80, 0);
      exp_sel = 2'd2; exp_addr = vb + AW'(h) * STRIDE; run_state(8'h80, 0);
      exp_sel = 2'd3; exp_addr = xb;                   run_state(8'h80, 0);
      exp_sel = 2'd1; run_state(8'h40, 0);
      exp_sel = 2'd0; run_state(8'h70, 1);
      while (1) begin
        run_state(8'h04, 0);
        run_state((t > 0) ? 8'h0A : 8'h08, 1);
        t++;
        exp_tok = t[SW-1:0];
        if (t == 1) begin
          if (L == 1) break;
          continue;
        end
        if (int'(h) == abort_h) begin
          exp_en = 8'h01; noise(); next_cycle();
          exp_en = 8'h01; abort = 1'b1; dn[0] = 1'b1; next_cycle();
          exp_en = '0; exp_busy = 1'b0; exp_done = 1'b0;
          repeat (6) begin noise(); next_cycle(); end
          return;
        end
        run_state(8'h01, 0);
        if (t >= L) break;
      end
      run_state(8'h02, 0);
      run_state(8'h01, 0);
      if (h != NH - 1) begin exp_en = '0; noise(); next_cycle(); end
    end
    exp_busy = 1'b0; exp_done = 1'b1; exp_en = '0;
    next_cycle();
    exp_done = 1'b0;
    repeat (3) begin noise(); next_cycle(); end
  endtask

  int ls0, lq0, dc0, n0;
  int hv0 [4];
  logic [AW-1:0] qb;

  initial begin
    repeat (3) next_cycle();
    chk_on = 1;
    next_cycle();
    chk("rst_weight_addr", weight_addr, 32'h0);
    chk("rst_head_idx", 32'(head_idx), 32'h0);
    chk("rst_tok_idx", 32'(tok_idx), 32'h0);
    chk("rst_weight_sel", 32'(weight_sel), 32'h0);
    rst = 1'b0;
    next_cycle();

    // Fixed 3-cycle responses, one token per head: aligned join dones.
    fixed_d = 1; noise_on = 0;
    ls0 = ls_rise; lq0 = lq_rise; dc0 = done_cnt; n0 = addr_q.size();
    do_run(16'd1, 32'd8, 32'd9, 32'd10, 32'd11, -1);
    if (addr_q.size() < n0 + 4) chk("addr_seq_len", addr_q.size(), n0 + 4);
    else for (int k = 0; k < 4; k++) chk("addr_seq", addr_q[n0 + k], 32'(8 + k));
    chk("loadq_count_a", lq_rise - lq0, 4);
    chk("loadscore_count_a", ls_rise - ls0, 4);
    chk("done_count_a", done_cnt - dc0, 1);

    // Three tokens with fixed delays puts done_qk and done_softmax in the same cycle at tok=1.
    ls0 = ls_rise;
    do_run(16'd3, 32'h100, 32'h200, 32'h300, 32'h400, -1);
    chk("loadscore_count_fixed", ls_rise - ls0, 12);

    // Random delays and noise, three tokens per head.
    fixed_d = 0; noise_on = 1;
    qb = $urandom & 32'h0FFF_FFFF;
    ls0 = ls_rise; dc0 = done_cnt;
    for (int k = 0; k < 4; k++) hv0[k] = head_vis[k];
    do_run(16'd3, qb, $urandom, $urandom, $urandom, -1);
    chk("loadscore_count_b", ls_rise - ls0, 12);
    chk("done_count_b", done_cnt - dc0, 1);
    chk("head2_q_addr", h2_addr, qb + 32'h0002_0000);
    for (int k = 0; k < 4; k++) chk("head_visit", head_vis[k] - hv0[k], 1);

    // Zero length behaves as one token.
    ls0 = ls_rise;
    do_run(16'd0, $urandom, $urandom, $urandom, $urandom, -1);
    chk("loadscore_count_len0", ls_rise - ls0, 4);

    // start and new config while busy are ignored.
    mid_start = 1;
    ls0 = ls_rise; dc0 = done_cnt;
    do_run(16'd2, $urandom, $urandom, $urandom, $urandom, -1);
    chk("loadscore_count_midstart", ls_rise - ls0, 8);
    chk("done_count_midstart", done_cnt - dc0, 1);
    mid_start = 0;

    // Abort during a score store of head 1, then restart from head 0.
    ls0 = ls_rise; dc0 = done_cnt;
    do_run(16'd2, $urandom, $urandom, $urandom, $urandom, 1);
    chk("done_count_abort", done_cnt - dc0, 0);
    chk("loadscore_count_abort", ls_rise - ls0, 3);
    dc0 = done_cnt;
    do_run(16'd2, $urandom, $urandom, $urandom, $urandom, -1);
    chk("done_count_restart", done_cnt - dc0, 1);

    for (int r = 0; r < 3; r++) begin
      do_run(16'($urandom_range(1, 4)), $urandom, $urandom, $urandom, $urandom, -1);
    end

    chk_on = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "time limit");
  end

endmodule
